// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// HAZARD_FORWARDING_EN selects load-use-only hazards in hazard_detect.
package hazard_ctrl_pkg;
    localparam int ADDR_REG_W_DEF = 4;

    localparam logic [0:0] HZ_IDLE = 1'b0;
    localparam logic [0:0] HZ_BUSY = 1'b1;

    // Width able to hold 0..max_val, never below one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage status in, freeze/flush/stats out.
interface hazard_ctrl_if import hazard_ctrl_pkg::*; #(
    parameter int ADDR_REG_W = ADDR_REG_W_DEF,
    parameter int CNT_W      = 16
);
    logic [ADDR_REG_W-1:0] id_src1, id_src2, exe_dest, mem_dest;
    logic                  id_src1_v, id_src2_v;
    logic                  exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic                  branch_taken, mem_req, mem_ready;
    logic                  freeze_front, freeze_back, flush_if, flush_id, mem_err;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt;

    modport master (
        output id_src1, id_src2, id_src1_v, id_src2_v, exe_wb_en, exe_mem_r_en,
               exe_dest, mem_wb_en, mem_dest, branch_taken, mem_req, mem_ready,
        input  freeze_front, freeze_back, flush_if, flush_id, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_src1, id_src2, id_src1_v, id_src2_v, exe_wb_en, exe_mem_r_en,
               exe_dest, mem_wb_en, mem_dest, branch_taken, mem_req, mem_ready,
        output freeze_front, freeze_back, flush_if, flush_id, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// Combinational RAW matcher between ID sources and EXE/MEM destinations.
// HAZARD_FORWARDING_EN: only EXE load-use matches stall; otherwise any EXE/MEM match.
module hazard_detect import hazard_ctrl_pkg::*; #(
    parameter int ADDR_REG_W = ADDR_REG_W_DEF
) (
    input  logic [ADDR_REG_W-1:0] id_src1,
    input  logic [ADDR_REG_W-1:0] id_src2,
    input  logic                  id_src1_v,
    input  logic                  id_src2_v,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic [ADDR_REG_W-1:0] exe_dest,
    input  logic                  mem_wb_en,
    input  logic [ADDR_REG_W-1:0] mem_dest,
    output logic                  haz
);
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic exe_hit, mem_hit;

    assign exe_hit = exe_wb_en & ((id_src1_v & (id_src1 == exe_dest)) |
                                  (id_src2_v & (id_src2 == exe_dest)));
    assign mem_hit = mem_wb_en & ((id_src1_v & (id_src1 == mem_dest)) |
                                  (id_src2_v & (id_src2 == mem_dest)));

    // With forwarding, MEM results and EXE ALU results are bypassed; only loads must wait.
    assign haz = FWD_EN ? (exe_hit & exe_mem_r_en) : (exe_hit | mem_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// Freeze/flush sequencing for the 5-stage core, memory-wait FSM with timeout, stall/flush counters.
// HAZARD_FORWARDING_EN is consumed by hazard_detect.
module hazard_ctrl import hazard_ctrl_pkg::*; #(
    parameter int ADDR_REG_W  = ADDR_REG_W_DEF,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam int                WCNT_W    = cnt_width(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);

    logic              haz, mstall;
    logic              freeze_front, flush_if;
    logic [0:0]        state;
    logic [WCNT_W-1:0] wcnt;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    hazard_detect #(.ADDR_REG_W(ADDR_REG_W)) u_detect (
        .id_src1      (bus.id_src1),
        .id_src2      (bus.id_src2),
        .id_src1_v    (bus.id_src1_v),
        .id_src2_v    (bus.id_src2_v),
        .exe_wb_en    (bus.exe_wb_en),
        .exe_mem_r_en (bus.exe_mem_r_en),
        .exe_dest     (bus.exe_dest),
        .mem_wb_en    (bus.mem_wb_en),
        .mem_dest     (bus.mem_dest),
        .haz          (haz)
    );

    // Priority: memory stall > taken branch > RAW hazard. A branch squashes ID, so its hazard is moot.
    assign mstall       = bus.mem_req & ~bus.mem_ready;
    assign freeze_front = mstall | (~bus.branch_taken & haz);
    assign flush_if     = ~mstall & bus.branch_taken;

    assign bus.freeze_front = freeze_front;
    assign bus.freeze_back  = mstall;
    assign bus.flush_if     = flush_if;
    assign bus.flush_id     = ~mstall & (bus.branch_taken | haz);
    assign bus.mem_err      = mem_err;
    assign bus.stall_cnt    = stall_cnt;
    assign bus.flush_cnt    = flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HZ_IDLE;
            wcnt      <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == HZ_IDLE) begin
                wcnt <= '0;
                if (mstall) state <= HZ_BUSY;
            end else begin
                if (wcnt == TIMEOUT_V) mem_err <= 1'b1;
                if (bus.mem_ready || !bus.mem_req) begin
                    state <= HZ_IDLE;
                    wcnt  <= '0;
                end else if (wcnt != TIMEOUT_V) begin
                    // Hold at the limit so a long wait cannot wrap and re-arm.
                    wcnt <= wcnt + 1'b1;
                end
            end
            if (freeze_front && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_if && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan scenarios, then randomized traffic vs a reference model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int AW  = 4;
    localparam int CW  = 4;
    localparam int TO  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.ADDR_REG_W(AW), .CNT_W(CW)) bus ();

    hazard_ctrl #(.ADDR_REG_W(AW), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference state: length of the current run of consecutive memory-stall cycles,
    // plus the sticky error and the two counters.
    int m_streak = 0;
    bit m_err    = 1'b0;
    int m_scnt   = 0;
    int m_fcnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit src_match(input logic [AW-1:0] dst, input logic wb);
        return wb && ((bus.id_src1_v && bus.id_src1 == dst) || (bus.id_src2_v && bus.id_src2 == dst));
    endfunction

    function automatic bit model_haz();
`ifdef HAZARD_FORWARDING_EN
        return bus.exe_mem_r_en && src_match(bus.exe_dest, bus.exe_wb_en);
`else
        return src_match(bus.exe_dest, bus.exe_wb_en) || src_match(bus.mem_dest, bus.mem_wb_en);
`endif
    endfunction

    // One clock: check combinational outputs, advance model across the edge, check registered state.
    task automatic tick();
        bit ms, ff, fb, fi, fd;
        ms = bus.mem_req && !bus.mem_ready;
        fb = ms;
        if (ms) begin
            ff = 1; fi = 0; fd = 0;
        end else if (bus.branch_taken) begin
            ff = 0; fi = 1; fd = 1;
        end else begin
            ff = model_haz(); fi = 0; fd = ff;
        end
        #2;
        chk("freeze_front", 32'(bus.freeze_front), 32'(ff));
        chk("freeze_back",  32'(bus.freeze_back),  32'(fb));
        chk("flush_if",     32'(bus.flush_if),     32'(fi));
        chk("flush_id",     32'(bus.flush_id),     32'(fd));
        if (rst) begin
            m_streak = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            // Waiting since streak cycles means BUSY with wait count streak-1 (capped at TO).
            if (m_streak >= TO + 1) m_err = 1;
            if (ff) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
            if (fi) m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
            m_streak = ms ? m_streak + 1 : 0;
        end
        @(posedge clk);
        #1;
        chk("mem_err",   32'(bus.mem_err),   32'(m_err));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_scnt));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_fcnt));
        chk("fsm_state", 32'(dut.state),     32'((m_streak > 0) ? HZ_BUSY : HZ_IDLE));
    endtask

    task automatic clear_inputs();
        bus.id_src1 = '0; bus.id_src2 = '0; bus.id_src1_v = 0; bus.id_src2_v = 0;
        bus.exe_wb_en = 0; bus.exe_mem_r_en = 0; bus.exe_dest = '0;
        bus.mem_wb_en = 0; bus.mem_dest = '0;
        bus.branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick(); tick();
        chk("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        rst = 0;

        // RAW hazard on r3 from a load in EXE: stalls in either build
        bus.id_src1 = 3; bus.id_src1_v = 1; bus.exe_dest = 3; bus.exe_wb_en = 1; bus.exe_mem_r_en = 1;
        tick();
        chk("haz_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        // Same match, not a load: only stalls without forwarding
        bus.exe_mem_r_en = 0;
        tick();
        // Branch together with the hazard: branch wins, no stall counted
        bus.exe_mem_r_en = 1; bus.branch_taken = 1;
        tick();
        clear_inputs();

        // Three wait cycles with a branch pending, then release services the branch
        bus.branch_taken = 1; bus.mem_req = 1; bus.mem_ready = 0;
        repeat (3) tick();
        bus.mem_ready = 1;
        tick();
        clear_inputs();
        tick();

        // Timeout: hold waiting past the limit, then release; error stays sticky
        bus.mem_req = 1;
        repeat (7) tick();
        chk("timeout_err", 32'(bus.mem_err), 32'd1);
        bus.mem_ready = 1;
        tick();
        clear_inputs();
        repeat (2) tick();
        chk("err_sticky", 32'(bus.mem_err), 32'd1);

        // Reset on the 2nd BUSY cycle
        bus.mem_req = 1;
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rst_err", 32'(bus.mem_err), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(HZ_IDLE));
        clear_inputs();
        tick();

        // Randomized traffic; some phases make memory slow enough to time out
        for (int c = 0; c < 3000; c++) begin
            bit slow;
            slow = ((c / 250) % 2) == 1;
            bus.id_src1      = AW'($urandom_range(0, 3));
            bus.id_src2      = AW'($urandom_range(0, 3));
            bus.id_src1_v    = 1'($urandom);
            bus.id_src2_v    = 1'($urandom);
            bus.exe_wb_en    = 1'($urandom);
            bus.exe_mem_r_en = 1'($urandom);
            bus.exe_dest     = AW'($urandom_range(0, 3));
            bus.mem_wb_en    = 1'($urandom);
            bus.mem_dest     = AW'($urandom_range(0, 3));
            bus.branch_taken = ($urandom_range(0, 3) == 0);
            bus.mem_req      = slow ? ($urandom_range(0, 15) != 0) : 1'($urandom);
            bus.mem_ready    = slow ? ($urandom_range(0, 7) == 0) : 1'($urandom);
            rst              = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
